// File: rtl/config_write_arbiter_if.sv
// Requester-side write handshakes plus the arbitrated eFPGA self-write port.
// The arbiter uses the slave view; requesters or the bench drive the master view.
interface config_write_arbiter_if;
   logic [31:0] usb_data_i;
   logic        usb_valid_i;
   logic        usb_ready_o;
   logic [31:0] soc_data_i;
   logic        soc_valid_i;
   logic        soc_ready_o;
   logic [31:0] efpga_write_data_o;
   logic        efpga_write_strobe_o;
   logic [1:0]  owner_o;
   logic        busy_o;
   logic        timeout_o;

   modport slave (
      input  usb_data_i, usb_valid_i, soc_data_i, soc_valid_i,
      output usb_ready_o, soc_ready_o, efpga_write_data_o, efpga_write_strobe_o,
      output owner_o, busy_o, timeout_o
   );

   modport master (
      output usb_data_i, usb_valid_i, soc_data_i, soc_valid_i,
      input  usb_ready_o, soc_ready_o, efpga_write_data_o, efpga_write_strobe_o,
      input  owner_o, busy_o, timeout_o
   );
endinterface

// File: rtl/config_write_arbiter.sv
// Arbitrates the eFPGA self-configuration write port between USB and SoC requesters,
// locking one owner for a whole sync..desync bitstream session with enforced strobe spacing.
module config_write_arbiter #(
   parameter logic [31:0] SYNC_WORD      = 32'hFAB0_FAB1,
   parameter int          DESYNC_FLAG    = 20,
   parameter int          FRAME_WORDS    = 4,
   parameter int          STROBE_GAP     = 2,
   parameter int          TIMEOUT_CYCLES = 1024
) (
   input logic                   clk_system_i,
   input logic                   reset_n_i,
   config_write_arbiter_if.slave bus
);

   localparam int GW = $clog2(STROBE_GAP + 2);
   localparam int WW = $clog2(FRAME_WORDS + 2);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 2);

   localparam logic [GW-1:0] GAP_LOAD  = GW'(STROBE_GAP);
   localparam logic [WW-1:0] WORD_LOAD = WW'(FRAME_WORDS);
   localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [TW-1:0] TO_MAX    = TW'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} state_t;
   typedef enum logic [1:0] {OWN_NONE = 2'b00, OWN_USB = 2'b01, OWN_SOC = 2'b10} owner_t;

   state_t        state_q, state_d;
   owner_t        owner_q, owner_d;
   logic          usb_ready_q, usb_ready_d;
   logic          soc_ready_q, soc_ready_d;
   logic          prio_soc_q;
   logic [GW-1:0] gap_q;
   logic [WW-1:0] word_cnt_q;
   logic [TW-1:0] to_cnt_q;
   logic [31:0]   data_q;
   logic          strobe_q;
   logic          timeout_q;

   logic        usb_acc, soc_acc, acc;
   logic [31:0] acc_word;
   logic        is_sync, is_desync, owner_valid, timeout_hit, last_data;

   assign usb_acc   = bus.usb_valid_i & usb_ready_q;
   assign soc_acc   = bus.soc_valid_i & soc_ready_q;
   assign acc       = usb_acc | soc_acc;
   assign acc_word  = usb_acc ? bus.usb_data_i : bus.soc_data_i;
   assign is_sync   = (acc_word == SYNC_WORD);
   assign is_desync = acc_word[DESYNC_FLAG];
   assign last_data = (word_cnt_q <= WW'(1));

   always_comb begin
      case (owner_q)
         OWN_USB: owner_valid = bus.usb_valid_i;
         OWN_SOC: owner_valid = bus.soc_valid_i;
         default: owner_valid = 1'b0;
      endcase
   end

   // Idle cycles of the owner only count once the session is locked.
   assign timeout_hit = (state_q != ST_IDLE) && !owner_valid && (to_cnt_q == TO_LAST);

   always_ff @(posedge clk_system_i or negedge reset_n_i) begin
      if (!reset_n_i) state_q <= ST_IDLE;
      // NOTE: registers take <= so every flop samples pre-edge values regardless of block order.
      else            state_q <= state_d;
   end

   always_comb begin
      // NOTE: default assignment first so no path leaves state_d unassigned (no inferred latch).
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (acc && is_sync) state_d = ST_ADDR;
         ST_ADDR: begin
            if (timeout_hit)  state_d = ST_IDLE;
            else if (acc)     state_d = is_desync ? ST_IDLE : ST_DATA;
         end
         ST_DATA: begin
            if (timeout_hit)            state_d = ST_IDLE;
            else if (acc && last_data)  state_d = ST_ADDR;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      usb_ready_d = 1'b0;
      soc_ready_d = 1'b0;
      owner_d     = owner_q;
      if (!acc && gap_q == '0 && !timeout_hit) begin
         case (state_q)
            ST_IDLE: begin
               if (bus.usb_valid_i && bus.soc_valid_i) begin
                  usb_ready_d = !prio_soc_q;
                  soc_ready_d = prio_soc_q;
               end else begin
                  usb_ready_d = bus.usb_valid_i;
                  soc_ready_d = bus.soc_valid_i;
               end
            end
            default: begin
               usb_ready_d = (owner_q == OWN_USB);
               soc_ready_d = (owner_q == OWN_SOC);
            end
         endcase
      end
      if (timeout_hit)
         owner_d = OWN_NONE;
      else if (acc && state_q == ST_IDLE && is_sync)
         owner_d = usb_acc ? OWN_USB : OWN_SOC;
      else if (acc && state_q == ST_ADDR && is_desync)
         owner_d = OWN_NONE;
   end

   always_ff @(posedge clk_system_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         owner_q     <= OWN_NONE;
         usb_ready_q <= 1'b0;
         soc_ready_q <= 1'b0;
         prio_soc_q  <= 1'b0;
         gap_q       <= '0;
         word_cnt_q  <= '0;
         to_cnt_q    <= '0;
         data_q      <= '0;
         strobe_q    <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         owner_q     <= owner_d;
         usb_ready_q <= usb_ready_d;
         soc_ready_q <= soc_ready_d;
         strobe_q    <= acc;
         timeout_q   <= timeout_hit;
         if (acc) begin
            data_q     <= acc_word;
            prio_soc_q <= usb_acc;
            gap_q      <= GAP_LOAD;
         end else if (gap_q != '0) begin
            gap_q <= gap_q - GW'(1);
         end
         if (acc && state_q == ST_ADDR)
            word_cnt_q <= WORD_LOAD;
         else if (acc && state_q == ST_DATA && word_cnt_q != '0)
            word_cnt_q <= word_cnt_q - WW'(1);
         if (state_q == ST_IDLE || owner_valid || timeout_hit)
            to_cnt_q <= '0;
         else if (to_cnt_q != TO_MAX)
            to_cnt_q <= to_cnt_q + TW'(1);
      end
   end

   assign bus.usb_ready_o          = usb_ready_q;
   assign bus.soc_ready_o          = soc_ready_q;
   assign bus.efpga_write_data_o   = data_q;
   assign bus.efpga_write_strobe_o = strobe_q;
   assign bus.owner_o              = owner_q;
   assign bus.busy_o               = (owner_q != OWN_NONE);
   assign bus.timeout_o            = timeout_q;

endmodule

// File: tb/tb_config_write_arbiter.sv
// Scoreboard bench for config_write_arbiter: directed sequences push hand-computed strobes,
// a negedge monitor pops and compares every strobe and timeout pulse.
module tb_config_write_arbiter;

   localparam logic [31:0] SYNC = 32'hFAB0_FAB1;

   logic clk_system_i = 1'b0;
   logic reset_n_i    = 1'b0;

   config_write_arbiter_if bus();

   config_write_arbiter #(
      .SYNC_WORD      (SYNC),
      .DESYNC_FLAG    (20),
      .FRAME_WORDS    (4),
      .STROBE_GAP     (2),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk_system_i (clk_system_i),
      .reset_n_i    (reset_n_i),
      .bus          (bus)
   );

   always #5 clk_system_i = ~clk_system_i;

   typedef struct packed {
      logic [31:0] data;
      logic [1:0]  owner;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   cyc      = 0;
   int   last_strobe_cyc = 0;
   bit   have_last = 1'b0;
   int   to_pulses = 0;
   int   soc_ready_in_lock = 0;
   int   both_ready = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
   endtask

   task automatic expect_word(input logic [31:0] d, input logic [1:0] o);
      exp_t e;
      e.data  = d;
      e.owner = o;
      exp_q.push_back(e);
   endtask

   // Called at a negedge; returns at the negedge after the accepting posedge.
   task automatic send(input bit soc, input logic [31:0] w);
      bit done = 1'b0;
      if (soc) begin bus.soc_data_i = w; bus.soc_valid_i = 1'b1; end
      else     begin bus.usb_data_i = w; bus.usb_valid_i = 1'b1; end
      for (int n = 0; n < 300 && !done; n++) begin
         if (soc ? bus.soc_ready_o : bus.usb_ready_o) done = 1'b1;
         else @(negedge clk_system_i);
      end
      if (done) begin
         @(posedge clk_system_i);
         @(negedge clk_system_i);
      end else begin
         check(soc ? "soc_send_wait" : "usb_send_wait", 64'd0, 64'd1);
      end
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk_system_i);
      repeat (2) @(negedge clk_system_i);
      check(name, exp_q.size(), 0);
   endtask

   logic [31:0] session_words [7];
   logic [1:0]  session_owner [7];

   task automatic push_session();
      for (int i = 0; i < 7; i++) expect_word(session_words[i], session_owner[i]);
   endtask

   task automatic send_session();
      for (int i = 0; i < 7; i++) send(1'b0, session_words[i]);
      bus.usb_valid_i = 1'b0;
   endtask

   // Monitor: pops the scoreboard on every strobe, checks spacing and timeout pulses.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk_system_i);
         cyc++;
         if (bus.soc_ready_o && bus.owner_o == 2'b01) soc_ready_in_lock++;
         if (bus.usb_ready_o && bus.soc_ready_o) both_ready++;
         if (bus.efpga_write_strobe_o) begin
            if (have_last) check("strobe_spacing_ge3", (cyc - last_strobe_cyc) >= 3, 1);
            last_strobe_cyc = cyc;
            have_last = 1'b1;
            check("strobe_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("strobe_data", bus.efpga_write_data_o, e.data);
               check("strobe_owner_busy", {bus.owner_o, bus.busy_o}, {e.owner, e.owner != 2'b00});
            end
         end
         if (bus.timeout_o) begin
            to_pulses++;
            check("timeout_latency", cyc - last_strobe_cyc, 16);
            check("timeout_release", {bus.owner_o, bus.busy_o}, 3'b000);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      session_words = '{SYNC, 32'h0000_0003, SYNC, 32'h0010_0000, 32'h0000_00C3,
                        32'h5555_AAAA, 32'h0010_0000};
      session_owner = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00};
      bus.usb_data_i  = '0;
      bus.usb_valid_i = 1'b0;
      bus.soc_data_i  = '0;
      bus.soc_valid_i = 1'b0;

      // Reset state
      reset_n_i = 1'b0;
      repeat (3) @(negedge clk_system_i);
      check("rst_data", bus.efpga_write_data_o, 32'h0);
      check("rst_flags", {bus.efpga_write_strobe_o, bus.owner_o, bus.busy_o, bus.timeout_o,
                          bus.usb_ready_o, bus.soc_ready_o}, 7'b0);
      reset_n_i = 1'b1;
      @(negedge clk_system_i);

      // Round-robin from reset: USB, SoC, USB, SoC
      expect_word(32'hA000_0001, 2'b00);
      expect_word(32'hB000_0001, 2'b00);
      expect_word(32'hA000_0002, 2'b00);
      expect_word(32'hB000_0002, 2'b00);
      fork
         begin send(1'b0, 32'hA000_0001); send(1'b0, 32'hA000_0002); bus.usb_valid_i = 1'b0; end
         begin send(1'b1, 32'hB000_0001); send(1'b1, 32'hB000_0002); bus.soc_valid_i = 1'b0; end
      join
      drain("rr_drained");

      // Single unlocked write
      expect_word(32'h1234_5678, 2'b00);
      send(1'b0, 32'h1234_5678);
      bus.usb_valid_i = 1'b0;
      drain("single_drained");
      check("single_busy_after", {bus.owner_o, bus.busy_o}, 3'b000);

      // Full locked session; data words mimicking sync/desync are plain data
      push_session();
      send_session();
      drain("session_drained");
      check("session_released", {bus.owner_o, bus.busy_o}, 3'b000);

      // Contention: SoC waits for the USB desync
      soc_ready_in_lock = 0;
      push_session();
      expect_word(32'hDEAD_BEEF, 2'b00);
      fork
         send_session();
         begin
            repeat (6) @(negedge clk_system_i);
            send(1'b1, 32'hDEAD_BEEF);
            bus.soc_valid_i = 1'b0;
         end
      join
      drain("contention_drained");
      check("soc_ready_in_usb_lock", soc_ready_in_lock, 0);
      check("no_spurious_timeout", to_pulses, 0);

      // Timeout: USB stalls after address, pending SoC word granted next
      expect_word(SYNC, 2'b01);
      expect_word(32'h0000_0003, 2'b01);
      expect_word(32'hC0FF_EE00, 2'b00);
      fork
         begin send(1'b0, SYNC); send(1'b0, 32'h0000_0003); bus.usb_valid_i = 1'b0; end
         begin
            repeat (3) @(negedge clk_system_i);
            send(1'b1, 32'hC0FF_EE00);
            bus.soc_valid_i = 1'b0;
         end
      join
      drain("timeout_drained");
      check("timeout_pulse_count", to_pulses, 1);

      // Reset in the middle of a frame
      expect_word(SYNC, 2'b01);
      expect_word(32'h0000_0003, 2'b01);
      expect_word(32'h0000_0D00, 2'b01);
      expect_word(32'h0000_0D01, 2'b01);
      send(1'b0, SYNC);
      send(1'b0, 32'h0000_0003);
      send(1'b0, 32'h0000_0D00);
      send(1'b0, 32'h0000_0D01);
      bus.usb_valid_i = 1'b0;
      check("pre_reset_lock", {bus.efpga_write_strobe_o, bus.owner_o, bus.busy_o}, 4'b1011);
      #2 reset_n_i = 1'b0;
      #1;
      check("mid_rst_data", bus.efpga_write_data_o, 32'h0);
      check("mid_rst_flags", {bus.efpga_write_strobe_o, bus.owner_o, bus.busy_o,
                              bus.usb_ready_o, bus.soc_ready_o}, 6'b0);
      repeat (2) @(negedge clk_system_i);
      reset_n_i = 1'b1;
      @(negedge clk_system_i);
      check("mid_rst_queue_empty", exp_q.size(), 0);
      expect_word(32'h0000_1111, 2'b00);
      send(1'b0, 32'h0000_1111);
      bus.usb_valid_i = 1'b0;
      drain("post_rst_drained");
      check("never_both_ready", both_ready, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/config_write_arbiter.md
Name: config_write_arbiter

Overview:
- Shares the eFPGA self-configuration write port (32-bit data plus 1-cycle strobe) between two requesters: the USB controller and the SoC (Ibex) bus bridge.
- Grants one requester at a time and locks the grant for a whole bitstream session, from sync word to desync address word, so the two streams never interleave.
- Enforces a minimum strobe spacing.
- Sits between the controller/SoC write outputs and the eFPGA_top SelfWriteData/SelfWriteStrobe inputs.

Parameters:
- SYNC_WORD, 32'hFAB0_FAB1, word that opens a locked session.
- DESYNC_FLAG, 20, bit index in an address word that ends the session.
- FRAME_WORDS, 4, data words following each address word (= NUMBER_OF_ROWS).
- STROBE_GAP, 2, idle cycles forced after each accepted word (0 allowed).
- TIMEOUT_CYCLES, 1024, consecutive owner-idle cycles before a locked session is aborted.

Ports:
- clk_system_i  in  1  system clock; the only clock.
- reset_n_i  in  1  asynchronous, active-low reset.
- usb_data_i  in  32  USB requester write word.
- usb_valid_i  in  1  USB word valid.
- usb_ready_o  out  1  USB word accepted when valid&&ready.
- soc_data_i  in  32  SoC requester write word.
- soc_valid_i  in  1  SoC word valid.
- soc_ready_o  out  1  SoC word accepted when valid&&ready.
- efpga_write_data_o  out  32  word to SelfWriteData.
- efpga_write_strobe_o  out  1  one-cycle pulse to SelfWriteStrobe.
- owner_o  out  2  00 none, 01 USB, 10 SoC (current lock).
- busy_o  out  1  high while a session is locked.
- timeout_o  out  1  one-cycle pulse on session abort.

Behaviour:
- Reset (async, immediate): all outputs 0, state IDLE, gap counter 0, priority pointer = USB. Reset mid-session drops the lock; no strobe is emitted.
- ready_o is registered and depends on state, grant and gap counter only, never on same-cycle valid. At most one ready_o is high per cycle.
- Accept: data is captured on the valid&&ready edge. On the next cycle efpga_write_data_o holds the word and efpga_write_strobe_o=1 for exactly 1 cycle (latency 1). efpga_write_data_o holds its value between strobes.
- Gap: after every accept, both ready_o stay low for 1+STROBE_GAP cycles, so strobes are ≥ STROBE_GAP+1 cycles apart.
- States:
  - IDLE: ready is offered to a requester per round-robin. If both are valid, the one not granted last wins; after reset USB wins. If only one is valid, it is granted. If neither is valid, no ready.
    - Accepted word == SYNC_WORD: lock owner, busy_o=1, go ADDR.
    - Any other word: forwarded as a single unlocked write, stay IDLE, pointer updated.
  - ADDR: only the owner's ready may assert. Accepted word is forwarded.
    - Bit DESYNC_FLAG=1: release (owner_o=00, busy_o=0 on the strobe cycle), go IDLE.
    - Bit DESYNC_FLAG=0: load word counter = FRAME_WORDS, go DATA.
  - DATA: only the owner is served. Each accept decrements the counter; at 0, go ADDR. A data word equal to SYNC_WORD or with bit DESYNC_FLAG set is plain data and is not interpreted.
- Non-owner during a lock: its valid is ignored (ready low); it is served after release.
- Timeout: in ADDR/DATA, a counter increments each cycle the owner's valid is low and clears on an owner-valid cycle. On reaching TIMEOUT_CYCLES: timeout_o pulses 1 cycle, lock is released, go IDLE, and a partially written frame is abandoned (no padding strobes).
- SYNC_WORD received in ADDR: treated as an address word (bit 20 of 32'hFAB0_FAB1 = 1, so the session ends).
- Counters are sized by $clog2 of the parameter +1 and saturate, with no wrap.

Test Plan:
- Single unlocked write: usb_valid with 32'h1234_5678 in IDLE → usb_ready 1 cycle; strobe 1 cycle later with data 32'h1234_5678; owner_o stays 00.
- Full session: USB sends FAB0_FAB1, addr 32'h0000_0003, 4 data words, addr 32'h0010_0000.
  - Required: 7 strobes, each ≥3 cycles apart (STROBE_GAP=2).
  - owner_o=01 and busy_o=1 from the first strobe until the last strobe, then 00/0.
- Contention: the SoC asserts valid mid-USB-session with 32'hDEAD_BEEF.
  - Required: soc_ready stays 0 until the USB desync strobe.
  - The SoC word is then forwarded on the next grant, with no interleaving.
- Round-robin: both valid with non-sync words from reset → USB, SoC, USB, SoC grant order across 4 accepts.
- Timeout (TIMEOUT_CYCLES=16): USB sends sync + address, then drops valid → timeout_o pulses exactly 16 cycles after the last accept; owner_o→00; a pending SoC word is granted next.
- Reset mid-DATA: assert reset_n_i low after 2 of 4 data words → strobe, busy_o, owner_o and both ready_o go 0 immediately. After release, a USB non-sync word is handled as an unlocked write.
